// File: rtl/mem_access_ctrl.sv
// Memory access controller between the CPU MEM stage and the SRAM/serial block.
// Sequences load/store bus cycles, stalls the pipeline and returns extended load data.
module mem_access_ctrl #(
  parameter int unsigned RD_WAIT_CYCLES  = 1,
  parameter int unsigned WR_PULSE_CYCLES = 1
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_sign_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        mem_err_o,
  output logic        stall_req_o,
  output logic        ram_ce_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_we_n_o,
  output logic [3:0]  ram_sel_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned     CNT_W   = 3;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE_CYCLES - 1);
  localparam logic [31:0]     SERIAL_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0]     SERIAL_STAT_ADDR = 32'hBFD0_03FC;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [3:0]       lane_q, lane_d;
  logic             ram_ce_q, ram_ce_d;
  logic             ram_we_n_q, ram_we_n_d;
  logic [3:0]       ram_sel_q, ram_sel_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_data_q, ram_data_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             mem_done_q, mem_done_d;
  logic             mem_err_q, mem_err_d;

  function automatic logic f_is_serial(input logic [31:0] a);
    return (a == SERIAL_DATA_ADDR) || (a == SERIAL_STAT_ADDR);
  endfunction

  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    return ((sz == 2'b01) && a_lo[0]) || (sz[1] && (a_lo != 2'b00));
  endfunction

  function automatic logic [3:0] f_lane_sel(input logic serial, input logic [1:0] sz,
                                            input logic [1:0] a_lo);
    logic [3:0] sel;
    sel = 4'b0000;
    if (!serial) begin
      case (sz)
        2'b00: begin
          sel       = 4'b1111;
          sel[a_lo] = 1'b0;
        end
        2'b01:   sel = a_lo[1] ? 4'b0011 : 4'b1100;
        default: sel = 4'b0000;
      endcase
    end
    return sel;
  endfunction

  // Serial registers use all lanes, but the data is still replicated so a byte lands low.
  function automatic logic [31:0] f_store_data(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load_data(input logic [1:0] sz, input logic sg,
                                              input logic [31:0] a, input logic [31:0] rd);
    logic [15:0] half;
    half = a[1] ? rd[31:16] : rd[15:0];
    if (f_is_serial(a)) return rd;
    case (sz)
      2'b00:   return sg ? {{24{rd[7]}}, rd[7:0]} : {24'h0, rd[7:0]};
      2'b01:   return sg ? {{16{half[15]}}, half} : {16'h0, half};
      default: return rd;
    endcase
  endfunction

  assign stall_req_o = !rst && (((state_q == S_IDLE) && mem_req_i) ||
                       (state_q inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD}));

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    sign_d      = sign_q;
    lane_d      = lane_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    mem_rdata_d = mem_rdata_q;
    mem_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          if (f_misaligned(mem_size_i, mem_addr_i[1:0])) begin
            state_d     = S_DONE;
            mem_err_d   = 1'b1;
            mem_rdata_d = '0;
          end else begin
            state_d    = mem_we_i ? S_WR_SETUP : S_RD;
            size_d     = mem_size_i;
            sign_d     = mem_sign_i;
            lane_d     = f_lane_sel(f_is_serial(mem_addr_i), mem_size_i, mem_addr_i[1:0]);
            ram_addr_d = mem_addr_i;
            ram_data_d = f_store_data(mem_size_i, mem_wdata_i);
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          cnt_d       = '0;
          state_d     = S_DONE;
          mem_rdata_d = f_load_data(size_q, sign_q, ram_addr_q, ram_rdata_i);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    ram_ce_d   = state_d inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    ram_we_n_d = (state_d != S_WR_PULSE);
    ram_sel_d  = ram_ce_d ? lane_d : 4'b1111;
    mem_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      lane_q      <= 4'b1111;
      ram_ce_q    <= 1'b0;
      ram_we_n_q  <= 1'b1;
      ram_sel_q   <= 4'b1111;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      lane_q      <= lane_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_n_q  <= ram_we_n_d;
      ram_sel_q   <= ram_sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign ram_ce_o    = ram_ce_q;
  assign ram_we_n_o  = ram_we_n_q;
  assign ram_sel_o   = ram_sel_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two parameterisations share one stimulus stream and are
// checked every cycle against a transaction-schedule model, plus literal directed cases.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int N = 2;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, mem_sign_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, ram_rdata_i;

  logic [31:0] rdata_o [N];
  logic        done_o  [N];
  logic        err_o   [N];
  logic        stall_o [N];
  logic        ce_o    [N];
  logic        we_n_o  [N];
  logic [3:0]  sel_o   [N];
  logic [31:0] raddr_o [N];
  logic [31:0] bus_o   [N];

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #10 clk_50M = ~clk_50M;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl #(
      .RD_WAIT_CYCLES (g == 0 ? 1 : 3),
      .WR_PULSE_CYCLES(g == 0 ? 1 : 2)
    ) u_dut (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .mem_req_i  (mem_req_i),
      .mem_we_i   (mem_we_i),
      .mem_size_i (mem_size_i),
      .mem_sign_i (mem_sign_i),
      .mem_addr_i (mem_addr_i),
      .mem_wdata_i(mem_wdata_i),
      .mem_rdata_o(rdata_o[g]),
      .mem_done_o (done_o[g]),
      .mem_err_o  (err_o[g]),
      .stall_req_o(stall_o[g]),
      .ram_ce_o   (ce_o[g]),
      .ram_addr_o (raddr_o[g]),
      .ram_data_o (bus_o[g]),
      .ram_we_n_o (we_n_o[g]),
      .ram_sel_o  (sel_o[g]),
      .ram_rdata_i(ram_rdata_i)
    );
  end

  function automatic int rdw(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int wrp(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_serial(input logic [31:0] a);
    return (a == 32'hBFD0_03F8) || (a == 32'hBFD0_03FC);
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
    int en;
    if (m_serial(a)) return 4'b0000;
    en = ((1 << nbytes(sz)) - 1) << a[1:0];
    return ~4'(en);
  endfunction

  function automatic logic [31:0] m_store(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int nb;
    nb = nbytes(sz);
    if (m_serial(a) || nb == 4) return rd;
    v = (nb == 1) ? (rd & 32'hFF) : ((rd >> (a[1] ? 16 : 0)) & 32'hFFFF);
    if (sg && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  // Model: pos counts cycles since the request (0 = idle); len is the request-to-done latency.
  int          pos    [N];
  int          len    [N];
  logic        mis_m  [N];
  logic        st_m   [N];
  logic [1:0]  sz_m   [N];
  logic        sg_m   [N];
  logic [31:0] addr_m [N];
  logic [31:0] wd_m   [N];
  logic [31:0] rdat_m [N];

  always @(posedge clk_50M) begin
    int p, l;
    logic mis, st, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;
    for (int i = 0; i < N; i++) begin
      p = pos[i]; l = len[i]; mis = mis_m[i]; st = st_m[i];
      sz = sz_m[i]; sg = sg_m[i]; a = addr_m[i]; wd = wd_m[i];
      if (rst) begin
        pos[i]    <= 0;
        rdat_m[i] <= 32'h0;
      end else begin
        if (p == 0) begin
          if (mem_req_i) begin
            mis = m_mis(mem_size_i, mem_addr_i);
            st  = mem_we_i; sz = mem_size_i; sg = mem_sign_i;
            a   = mem_addr_i; wd = mem_wdata_i;
            l   = mis ? 1 : (st ? 3 + wrp(i) : 1 + rdw(i));
            p   = 1;
          end
        end else if (p == l) begin
          p = 0;
        end else begin
          p = p + 1;
        end
        if (p != 0 && p == l) begin
          if (mis) rdat_m[i] <= 32'h0;
          else if (!st) rdat_m[i] <= m_load(sz, sg, a, ram_rdata_i);
        end
        pos[i] <= p; len[i] <= l; mis_m[i] <= mis; st_m[i] <= st;
        sz_m[i] <= sz; sg_m[i] <= sg; addr_m[i] <= a; wd_m[i] <= wd;
      end
    end
  end

  task automatic ck(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, i, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk_50M) begin
    logic act, st_act;
    #2;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        act    = (pos[i] >= 1) && (pos[i] < len[i]) && !mis_m[i];
        st_act = act && st_m[i];
        ck("stall", i, 32'(stall_o[i]),
           32'(!rst && ((pos[i] == 0) ? mem_req_i : (pos[i] < len[i]))));
        ck("ce", i, 32'(ce_o[i]), 32'(act));
        ck("we_n", i, 32'(we_n_o[i]),
           32'(!(st_act && pos[i] >= 2 && pos[i] <= 1 + wrp(i))));
        ck("sel", i, 32'(sel_o[i]), 32'(act ? m_sel(sz_m[i], addr_m[i]) : 4'b1111));
        if (act) ck("addr", i, raddr_o[i], addr_m[i]);
        if (st_act) ck("wdata", i, bus_o[i], m_store(sz_m[i], wd_m[i]));
        ck("done", i, 32'(done_o[i]), 32'(pos[i] != 0 && pos[i] == len[i]));
        ck("err", i, 32'(err_o[i]), 32'(pos[i] != 0 && pos[i] == len[i] && mis_m[i]));
        ck("rdata", i, rdata_o[i], rdat_m[i]);
      end
    end
  end

  int          o_lat [N];
  int          o_we  [N];
  int          o_ce  [N];
  logic [31:0] o_rd  [N];
  logic        o_err [N];
  logic [3:0]  o_sel [N];
  logic [31:0] o_dat [N];

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk_50M);
      mem_req_i = 1'b0;
      k++;
    end while (!(pos[0] == 0 && pos[1] == 0) && k < 20);
    ck("idle_timeout", 0, 32'(pos[0] + pos[1]), 32'h0);
  endtask

  // One directed access; records latency and bus activity for 12 cycles after the request.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_sign_i = sg;
    mem_addr_i = a; mem_wdata_i = wd; ram_rdata_i = rd;
    #1 ck("lit_req_stall", 0, 32'(stall_o[0]), 32'h1);
    for (int i = 0; i < N; i++) begin
      o_lat[i] = -1; o_we[i] = 0; o_ce[i] = 0; o_rd[i] = '0;
      o_err[i] = 1'b0; o_sel[i] = 4'hF; o_dat[i] = '0;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_50M);
      mem_req_i = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
        if (done_o[i] && o_lat[i] < 0) begin
          o_lat[i] = c; o_rd[i] = rdata_o[i]; o_err[i] = err_o[i];
        end
        if (!we_n_o[i]) o_we[i]++;
        if (ce_o[i]) begin
          o_ce[i]++; o_sel[i] = sel_o[i]; o_dat[i] = bus_o[i];
        end
      end
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_sign_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = '0; ram_rdata_i = '0;
    repeat (3) @(negedge clk_50M);
    #1;
    ck("lit_rst_ce", 0, 32'(ce_o[0]), 32'h0);
    ck("lit_rst_we_n", 0, 32'(we_n_o[0]), 32'h1);
    ck("lit_rst_sel", 0, 32'(sel_o[0]), 32'hF);
    ck("lit_rst_addr", 0, raddr_o[0], 32'h0);
    ck("lit_rst_data", 1, bus_o[1], 32'h0);
    ck("lit_rst_rdata", 0, rdata_o[0], 32'h0);
    ck("lit_rst_done", 0, 32'(done_o[0]), 32'h0);
    mem_req_i = 1'b1;
    #1 ck("lit_rst_stall", 0, 32'(stall_o[0]), 32'h0);
    @(negedge clk_50M);
    mem_req_i = 1'b0; rst = 1'b0; chk_en = 1'b1;

    issue(1'b0, 2'b10, 1'b0, 32'h8040_0010, 32'h0, 32'h1234_5678);
    ck("lit_wl_lat", 0, 32'(o_lat[0]), 32'd2);
    ck("lit_wl_lat", 1, 32'(o_lat[1]), 32'd4);
    ck("lit_wl_rdata", 0, o_rd[0], 32'h1234_5678);
    ck("lit_wl_sel", 0, 32'(o_sel[0]), 32'h0);
    ck("lit_wl_ce_cycles", 0, 32'(o_ce[0]), 32'd1);

    issue(1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'hA5A5_A580);
    ck("lit_lb_sel", 0, 32'(o_sel[0]), 32'h7);
    ck("lit_lb_rdata", 0, o_rd[0], 32'hFFFF_FF80);
    issue(1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'hA5A5_A580);
    ck("lit_lbu_rdata", 0, o_rd[0], 32'h0000_0080);

    issue(1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0);
    ck("lit_sh_data", 1, o_dat[1], 32'hABCD_ABCD);
    ck("lit_sh_sel", 1, 32'(o_sel[1]), 32'h3);
    ck("lit_sh_we_cycles", 1, 32'(o_we[1]), 32'd2);
    ck("lit_sh_ce_cycles", 1, 32'(o_ce[1]), 32'd4);
    ck("lit_sh_lat", 1, 32'(o_lat[1]), 32'd5);
    ck("lit_sh_lat", 0, 32'(o_lat[0]), 32'd4);

    issue(1'b0, 2'b10, 1'b0, 32'h8000_0006, 32'h0, 32'hDEAD_BEEF);
    ck("lit_mis_err", 0, 32'(o_err[0]), 32'h1);
    ck("lit_mis_lat", 0, 32'(o_lat[0]), 32'd1);
    ck("lit_mis_rdata", 0, o_rd[0], 32'h0);
    ck("lit_mis_ce", 0, 32'(o_ce[0]), 32'h0);
    ck("lit_mis_we", 0, 32'(o_we[0]), 32'h0);

    issue(1'b1, 2'b00, 1'b0, 32'hBFD0_03F8, 32'h0000_0041, 32'h0);
    ck("lit_ser_sel", 0, 32'(o_sel[0]), 32'h0);
    ck("lit_ser_data", 0, o_dat[0], 32'h4141_4141);
    ck("lit_ser_we", 0, 32'(o_we[0]), 32'd1);

    // Reset while both instances are in the write pulse.
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h8000_0100;
    mem_wdata_i = 32'hCAFE_F00D;
    for (int k = 0; k < 10 && pos[1] != 2; k++) begin
      @(negedge clk_50M);
      mem_req_i = 1'b0;
    end
    #1 ck("lit_mid_we_low", 0, 32'(we_n_o[0]), 32'h0);
    rst = 1'b1;
    #1 ck("lit_mid_stall", 1, 32'(stall_o[1]), 32'h0);
    @(negedge clk_50M);
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      ck("lit_mid_we_n", i, 32'(we_n_o[i]), 32'h1);
      ck("lit_mid_ce", i, 32'(ce_o[i]), 32'h0);
    end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_50M);
      #1 dones += int'(done_o[0]) + int'(done_o[1]);
    end
    ck("lit_mid_no_done", 0, 32'(dones), 32'h0);

    // Random traffic; req only toggles freely while no instance is idle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_50M);
      ram_rdata_i = $urandom;
      mem_we_i    = 1'($urandom);
      mem_size_i  = 2'($urandom);
      mem_sign_i  = 1'($urandom);
      mem_wdata_i = $urandom;
      case ($urandom_range(0, 7))
        0:       mem_addr_i = 32'hBFD0_03F8;
        1:       mem_addr_i = 32'hBFD0_03FC;
        default: mem_addr_i = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
      endcase
      if (pos[0] == 0 && pos[1] == 0) mem_req_i = ($urandom_range(0, 3) != 0);
      else if (pos[0] != 0 && pos[1] != 0) mem_req_i = 1'($urandom);
      else mem_req_i = 1'b0;
    end
    @(negedge clk_50M);
    mem_req_i = 1'b0;
    repeat (2) @(negedge clk_50M);
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sits between the CPU MEM stage and the SRAM/serial memory block.
- Turns MEM-stage load/store requests (byte/half/word, signed/unsigned) into timed SRAM-side bus cycles: address, lane enables, write data and a write-enable pulse.
- Holds the pipeline with stall_req_o until each access completes, then returns the aligned and extended load data.
- Flags misaligned accesses and suppresses them; they never reach the memory block.

Parameters:
- RD_WAIT_CYCLES, 1, cycles the read is held on the bus before data is sampled (1..4).
- WR_PULSE_CYCLES, 1, cycles ram_we_n_o is held low per store (1..4).

Ports:
- clk_50M  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk_50M
- mem_req_i  in  1  MEM stage has a load/store this cycle
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_sign_i  in  1  1 = sign-extend load, 0 = zero-extend
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data, right-aligned
- mem_rdata_o  out  32  load result
- mem_done_o  out  1  one-cycle pulse: access finished
- mem_err_o  out  1  one-cycle pulse with mem_done_o: misaligned, access suppressed
- stall_req_o  out  1  hold pipeline
- ram_ce_o  out  1  bus request to memory block
- ram_addr_o  out  32  bus address
- ram_data_o  out  32  lane-replicated store data
- ram_we_n_o  out  1  write enable, low active
- ram_sel_o  out  4  byte-lane enables, low active
- ram_rdata_i  in  32  data from memory block

Behaviour:
- Reset values:
  - state IDLE; all counters 0.
  - ram_ce_o=0, ram_we_n_o=1, ram_sel_o=4'b1111, ram_addr_o=0, ram_data_o=0.
  - mem_rdata_o=0, mem_done_o=0, mem_err_o=0.
  - stall_req_o=0 while rst=1.
- All ram_* outputs and mem_rdata_o/mem_done_o/mem_err_o are registered. stall_req_o is combinational.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Request capture (IDLE, mem_req_i=1): latch addr, size, sign, we, wdata.
- Alignment check at capture:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned -> DONE, with mem_err_o=1 and mem_rdata_o=0. No ram_ce_o, no we pulse.
- Aligned load: IDLE -> RD.
  - RD drives ram_ce_o=1, ram_we_n_o=1, address and sel.
  - Counter runs RD_WAIT_CYCLES cycles; ram_rdata_i is sampled on the last RD cycle.
  - Then -> DONE.
- Aligned store: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WR_PULSE_CYCLES cycles) -> WR_HOLD (1 cycle) -> DONE.
  - ram_we_n_o=0 only in WR_PULSE.
  - addr, sel and data stay stable from WR_SETUP through WR_HOLD.
- DONE: mem_done_o=1 for exactly this cycle, stall_req_o=0. Next state is always IDLE; mem_req_i in DONE is ignored.
- stall_req_o = (IDLE & mem_req_i) | (state in {RD, WR_SETUP, WR_PULSE, WR_HOLD}).
- Latency, from request cycle to done cycle:
  - load: 1 + RD_WAIT_CYCLES.
  - store: 3 + WR_PULSE_CYCLES.
  - misaligned: 1.
- Lane select:
  - byte: sel = all ones except bit addr[1:0] cleared.
  - half: addr[1]=0 -> 1100, addr[1]=1 -> 0011.
  - word: 0000.
- ram_addr_o = captured address unmodified.
- Serial registers 0xBFD003F8 / 0xBFD003FC: always use sel=0000 and word data path, regardless of size.
- Store data: byte replicated into all four lanes; half replicated into both halves; word unchanged.
- Load extract:
  - byte: the memory block returns the selected byte in ram_rdata_i[7:0]; use [7:0], then sign- or zero-extend per mem_sign_i.
  - half: use ram_rdata_i[15:0] if addr[1]=0, else [31:16]; then extend.
  - word: pass through.
- Outside RD/WR_* states: ram_ce_o=0, ram_we_n_o=1, ram_sel_o=1111.
- mem_rdata_o holds its value until the next DONE.
- Reset mid-operation: on the next clk_50M edge the state is IDLE and ram_we_n_o=1. No partial DONE pulse is produced.

Test Plan:
- Word load at 0x80400010, ram_rdata_i=0x12345678, default params -> ram_ce_o=1 and sel=0000 for 1 cycle; mem_done_o in cycle 2 with mem_rdata_o=0x12345678; stall_req_o=1 in cycles 0–1.
- Byte load at 0x80000003 with sign=1, ram_rdata_i[7:0]=0x80 -> sel=0111, mem_rdata_o=0xFFFFFF80. Repeat with sign=0 -> 0x00000080.
- Half store 0xABCD to 0x80000002, WR_PULSE_CYCLES=2 -> ram_data_o=0xABCDABCD, sel=0011; we_n low for exactly 2 cycles, bracketed by one setup and one hold cycle; done in cycle 5.
- Word load at 0x80000006 -> mem_err_o=1 and mem_done_o=1 in cycle 1; ram_ce_o never asserted; mem_rdata_o=0.
- Byte store 0x41 to 0xBFD003F8 -> sel=0000, ram_data_o=0x41414141, single we pulse.
- rst asserted during WR_PULSE -> ram_we_n_o=1 next cycle; state IDLE; no mem_done_o pulse; stall_req_o=0.
